// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Instruction-memory request/ready handshake between the fetch
//            stage (master) and the instruction memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic [31:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ready,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ready,
        output im_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch stage. Holds the PC, picks the next PC with
//            priority interrupt > eret > branch/jump > sequential, runs a
//            variable-latency memory handshake and presents the fetched slot
//            to the IF/ID register. In-flight requests are always drained.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] PC_LO      = 32'h0000_3000,
    parameter logic [31:0] PC_HI      = 32'h0000_4ffc
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        en,
    input  wire logic        br_take,
    input  wire logic [31:0] br_target,
    input  wire logic        int_req,
    input  wire logic        eret,
    input  wire logic [31:0] epc,
    fetch_unit_if.master     imem,
    output logic             validF,
    output logic [31:0]      instrF,
    output logic [31:0]      pcF,
    output logic [31:0]      pc4F,
    output logic [31:0]      pc8F,
    output logic             excF,
    output logic             busy
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] hold_buf;
    logic [31:0] hold_buf_next;
    logic [31:0] redir_pc;
    logic [31:0] redir_pc_next;

    logic        bad;
    logic        redirect;
    logic [31:0] redir_target;
    logic [31:0] seq_pc;
    logic        req;
    logic        slot;
    logic        slot_exc;
    logic [31:0] slot_instr;
    logic        outstanding;

    assign bad          = (pc[1:0] != 2'b00) || (pc < PC_LO) || (pc > PC_HI);
    assign redirect     = int_req | eret;
    assign redir_target = int_req ? EXC_VECTOR : epc;
    // br_take is only consumed when a slot is delivered, so the delay slot
    // always completes before the branch target is fetched.
    assign seq_pc       = br_take ? br_target : pc + 32'd4;

    // A request that has not completed this cycle must be drained before
    // any redirect can take effect.
    assign outstanding  = (state == DRAIN) ||
                          ((state == FETCH) && req && !imem.im_ready);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // PC, capture buffer and pending redirect target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            hold_buf <= 32'd0;
            redir_pc <= 32'd0;
        end else begin
            pc       <= pc_next;
            hold_buf <= hold_buf_next;
            redir_pc <= redir_pc_next;
        end
    end

    // Next-state and next-datapath selection; redirects override everything.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        hold_buf_next = hold_buf;
        redir_pc_next = redir_pc;
        if (redirect) begin
            if (outstanding) begin
                state_next    = DRAIN;
                redir_pc_next = redir_target;
            end else begin
                state_next = FETCH;
                pc_next    = redir_target;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (bad) begin
                        if (en) begin
                            pc_next = seq_pc;
                        end
                    end else if (imem.im_ready) begin
                        if (en) begin
                            pc_next = seq_pc;
                        end else begin
                            hold_buf_next = imem.im_rdata;
                            state_next    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (en) begin
                        pc_next    = seq_pc;
                        state_next = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem.im_ready) begin
                        pc_next    = redir_pc;
                        state_next = FETCH;
                    end
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    // Slot presentation and memory request; a redirect kills the slot.
    always_comb begin
        req        = 1'b0;
        slot       = 1'b0;
        slot_exc   = 1'b0;
        slot_instr = 32'd0;
        case (state)
            FETCH: begin
                if (bad) begin
                    slot     = 1'b1;
                    slot_exc = 1'b1;
                end else begin
                    req        = 1'b1;
                    slot       = imem.im_ready;
                    slot_instr = imem.im_rdata;
                end
            end
            HOLD: begin
                slot       = 1'b1;
                slot_instr = hold_buf;
            end
            DRAIN: begin
                req = 1'b1;
            end
            default: begin
                req = 1'b0;
            end
        endcase
        validF = slot && !redirect && reset;
        excF   = validF && slot_exc;
        instrF = (validF && !slot_exc) ? slot_instr : 32'd0;
        busy   = !validF;
    end

    // Held low while reset is asserted so memory sees the request abandoned.
    assign imem.im_req  = req && reset;
    assign imem.im_addr = {pc[31:2], 2'b00};

    assign pcF  = pc;
    assign pc4F = pc + 32'd4;
    assign pc8F = pc + 32'd8;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Testbench for fetch_unit: directed scenarios plus randomized
//            traffic against a behavioural model of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        br_take;
    logic [31:0] br_target;
    logic        int_req;
    logic        eret;
    logic [31:0] epc;
    logic        validF;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic [31:0] pc4F;
    logic [31:0] pc8F;
    logic        excF;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Memory model: configurable wait count, data derived from address.
    int dir_wait  = 0;
    int rwait     = 0;
    bit rand_mode = 1'b0;
    int wcnt      = 0;

    fetch_unit_if imem ();

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem.im_ready = imem.im_req && (wcnt >= (rand_mode ? rwait : dir_wait));
    assign imem.im_rdata = word_at(imem.im_addr);

    // Count wait cycles of the current request; draw a new wait on completion.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt <= 0;
        end else if (imem.im_ready) begin
            wcnt  <= 0;
            rwait <= $urandom_range(0, 3);
        end else if (imem.im_req) begin
            wcnt <= wcnt + 1;
        end
    end

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .br_take   (br_take),
        .br_target (br_target),
        .int_req   (int_req),
        .eret      (eret),
        .epc       (epc),
        .imem      (imem),
        .validF    (validF),
        .instrF    (instrF),
        .pcF       (pcF),
        .pc4F      (pc4F),
        .pc8F      (pc8F),
        .excF      (excF),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        en        = 1'b0;
        br_take   = 1'b0;
        br_target = 32'd0;
        int_req   = 1'b0;
        eret      = 1'b0;
        epc       = 32'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rand_mode = 1'b0;
        dir_wait  = 0;
        reset     = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (imem.im_req !== 1'b0) begin failures++; $display("FAIL reset_im_req: got %b expected 0", imem.im_req); end
        checks++; if (validF !== 1'b0) begin failures++; $display("FAIL reset_validF: got %b expected 0", validF); end
        checks++; if (instrF !== 32'd0) begin failures++; $display("FAIL reset_instrF: got %h expected 0", instrF); end
        checks++; if (excF !== 1'b0) begin failures++; $display("FAIL reset_excF: got %b expected 0", excF); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b expected 1", busy); end
        checks++; if (pcF !== 32'h3000) begin failures++; $display("FAIL reset_pcF: got %h expected 3000", pcF); end
        // Advance the PC, then assert reset between edges.
        tick();
        reset = 1'b1;
        en    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (pcF !== 32'h3000 || imem.im_req !== 1'b0) begin failures++; $display("FAIL async_reset: got pc=%h req=%b expected pc=3000 req=0", pcF, imem.im_req); end
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (imem.im_req !== 1'b1 || imem.im_addr !== 32'h3000) begin failures++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=3000", imem.im_req, imem.im_addr); end
        tick();
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp = 32'h3000 + 32'(4 * i);
            checks++; if (imem.im_req !== 1'b1 || imem.im_addr !== exp) begin failures++; $display("FAIL seq_addr%0d: got req=%b addr=%h expected addr=%h", i, imem.im_req, imem.im_addr, exp); end
            checks++; if (validF !== 1'b1 || pcF !== exp || instrF !== word_at(exp)) begin failures++; $display("FAIL seq_slot%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", i, validF, pcF, instrF, exp, word_at(exp)); end
            if (i == 0) begin
                checks++; if (pc8F !== 32'h3008 || pc4F !== 32'h3004) begin failures++; $display("FAIL seq_pc48: got pc4=%h pc8=%h expected 3004 3008", pc4F, pc8F); end
            end
            tick();
        end
    endtask

    task automatic test_hold();
        do_reset();
        dir_wait = 2;
        @(negedge clk);
        checks++; if (imem.im_req !== 1'b1 || imem.im_addr !== 32'h3000 || busy !== 1'b1) begin failures++; $display("FAIL hold_wait0: got req=%b addr=%h busy=%b expected 1 3000 1", imem.im_req, imem.im_addr, busy); end
        tick();
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_wait1: got busy=%b expected 1", busy); end
        tick();
        @(negedge clk);
        checks++; if (validF !== 1'b1 || instrF !== word_at(32'h3000)) begin failures++; $display("FAIL hold_arrive: got v=%b instr=%h expected v=1 instr=%h", validF, instrF, word_at(32'h3000)); end
        tick();
        en = 1'b1;
        @(negedge clk);
        checks++; if (imem.im_req !== 1'b0 || validF !== 1'b1 || instrF !== word_at(32'h3000)) begin failures++; $display("FAIL hold_state: got req=%b v=%b instr=%h expected 0 1 %h", imem.im_req, validF, instrF, word_at(32'h3000)); end
        tick();
        @(negedge clk);
        checks++; if (imem.im_req !== 1'b1 || imem.im_addr !== 32'h3004) begin failures++; $display("FAIL hold_next: got req=%b addr=%h expected 1 3004", imem.im_req, imem.im_addr); end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        en = 1'b1;
        @(negedge clk);
        tick();
        br_take   = 1'b1;
        br_target = 32'h3100;
        @(negedge clk);
        checks++; if (validF !== 1'b1 || pcF !== 32'h3004 || instrF !== word_at(32'h3004)) begin failures++; $display("FAIL br_delay_slot: got v=%b pc=%h instr=%h expected 1 3004 %h", validF, pcF, instrF, word_at(32'h3004)); end
        tick();
        br_take = 1'b0;
        @(negedge clk);
        checks++; if (imem.im_addr !== 32'h3100 || validF !== 1'b1 || pcF !== 32'h3100) begin failures++; $display("FAIL br_target: got addr=%h v=%b pc=%h expected 3100 1 3100", imem.im_addr, validF, pcF); end
        tick();
    endtask

    task automatic test_interrupt_eret();
        do_reset();
        en = 1'b1;
        tick();
        tick();
        dir_wait = 3;
        int_req  = 1'b1;
        @(negedge clk);
        checks++; if (imem.im_req !== 1'b1 || imem.im_addr !== 32'h3008 || validF !== 1'b0) begin failures++; $display("FAIL int_pending: got req=%b addr=%h v=%b expected 1 3008 0", imem.im_req, imem.im_addr, validF); end
        tick();
        int_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) dir_wait = 0;
            @(negedge clk);
            checks++; if (imem.im_req !== 1'b1 || imem.im_addr !== 32'h3008 || validF !== 1'b0) begin failures++; $display("FAIL int_drain%0d: got req=%b addr=%h v=%b expected 1 3008 0", k, imem.im_req, imem.im_addr, validF); end
            tick();
        end
        @(negedge clk);
        checks++; if (imem.im_req !== 1'b1 || imem.im_addr !== 32'h4180 || validF !== 1'b1 || pcF !== 32'h4180) begin failures++; $display("FAIL int_vector: got req=%b addr=%h v=%b pc=%h expected 1 4180 1 4180", imem.im_req, imem.im_addr, validF, pcF); end
        tick();
        eret = 1'b1;
        epc  = 32'h300c;
        @(negedge clk);
        checks++; if (validF !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL eret_kill: got v=%b busy=%b expected 0 1", validF, busy); end
        tick();
        eret = 1'b0;
        @(negedge clk);
        checks++; if (imem.im_addr !== 32'h300c || validF !== 1'b1) begin failures++; $display("FAIL eret_target: got addr=%h v=%b expected 300c 1", imem.im_addr, validF); end
        tick();
    endtask

    task automatic test_bad_addr();
        do_reset();
        en        = 1'b1;
        br_take   = 1'b1;
        br_target = 32'h3002;
        @(negedge clk);
        tick();
        br_target = 32'h5000;
        @(negedge clk);
        checks++; if (imem.im_req !== 1'b0 || validF !== 1'b1 || excF !== 1'b1 || instrF !== 32'd0 || pcF !== 32'h3002) begin failures++; $display("FAIL bad_misalign: got req=%b v=%b exc=%b instr=%h pc=%h expected 0 1 1 0 3002", imem.im_req, validF, excF, instrF, pcF); end
        tick();
        br_take = 1'b0;
        en      = 1'b0;
        @(negedge clk);
        checks++; if (imem.im_req !== 1'b0 || validF !== 1'b1 || excF !== 1'b1 || instrF !== 32'd0 || pcF !== 32'h5000) begin failures++; $display("FAIL bad_range: got req=%b v=%b exc=%b instr=%h pc=%h expected 0 1 1 0 5000", imem.im_req, validF, excF, instrF, pcF); end
        tick();
        int_req = 1'b1;
        @(negedge clk);
        checks++; if (pcF !== 32'h5000 || validF !== 1'b0) begin failures++; $display("FAIL bad_stall: got pc=%h v=%b expected 5000 0", pcF, validF); end
        tick();
        int_req = 1'b0;
        @(negedge clk);
        checks++; if (imem.im_req !== 1'b1 || imem.im_addr !== 32'h4180) begin failures++; $display("FAIL bad_int: got req=%b addr=%h expected 1 4180", imem.im_req, imem.im_addr); end
        tick();
    endtask

    function automatic logic [31:0] pick_target();
        int unsigned r;
        r = $urandom_range(0, 15);
        case (r)
            0:       return $urandom;
            1:       return 32'hffff_fffc;
            2:       return 32'h3000 + 32'(4 * $urandom_range(0, 32'h7ff)) + 32'd2;
            3:       return 32'h4ffc;
            4:       return 32'h2ffc;
            default: return 32'h3000 + 32'(4 * $urandom_range(0, 32'h7ff));
        endcase
    endfunction

    // Reference model: the PC being fetched, an optional captured word,
    // and an optional pending redirect that waits for the in-flight word.
    task automatic test_random();
        logic [31:0] m_pc;
        logic        m_have;
        logic [31:0] m_word;
        logic        m_drain;
        logic [31:0] m_redir;
        logic        is_bad, e_req, e_slot, e_valid, e_exc, redir;
        logic [31:0] e_instr, tgt;
        do_reset();
        rand_mode = 1'b1;
        m_pc    = 32'h3000;
        m_have  = 1'b0;
        m_word  = 32'd0;
        m_drain = 1'b0;
        m_redir = 32'd0;
        for (int n = 0; n < 4000; n++) begin
            en        = ($urandom_range(0, 3) != 0);
            br_take   = ($urandom_range(0, 7) == 0);
            br_target = pick_target();
            int_req   = ($urandom_range(0, 39) == 0);
            eret      = ($urandom_range(0, 39) == 0);
            epc       = pick_target();
            @(negedge clk);
            is_bad  = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h4ffc);
            e_req   = m_drain || (!m_have && !is_bad);
            e_slot  = !m_drain && (m_have || is_bad || imem.im_ready);
            redir   = int_req || eret;
            e_valid = e_slot && !redir;
            e_exc   = e_valid && !m_have && is_bad;
            e_instr = (!e_valid || e_exc) ? 32'd0 : (m_have ? m_word : imem.im_rdata);
            checks++; if (imem.im_req !== e_req) begin failures++; $display("FAIL rnd_req[%0d]: got %b expected %b", n, imem.im_req, e_req); end
            if (e_req) begin
                checks++; if (imem.im_addr !== m_pc) begin failures++; $display("FAIL rnd_addr[%0d]: got %h expected %h", n, imem.im_addr, m_pc); end
            end
            checks++; if (validF !== e_valid || busy !== !e_valid) begin failures++; $display("FAIL rnd_valid[%0d]: got v=%b busy=%b expected v=%b", n, validF, busy, e_valid); end
            checks++; if (excF !== e_exc) begin failures++; $display("FAIL rnd_exc[%0d]: got %b expected %b", n, excF, e_exc); end
            checks++; if (instrF !== e_instr) begin failures++; $display("FAIL rnd_instr[%0d]: got %h expected %h", n, instrF, e_instr); end
            checks++; if (pcF !== m_pc || pc4F !== m_pc + 32'd4 || pc8F !== m_pc + 32'd8) begin failures++; $display("FAIL rnd_pc[%0d]: got %h/%h/%h expected %h", n, pcF, pc4F, pc8F, m_pc); end
            tgt = int_req ? 32'h4180 : epc;
            if (redir) begin
                if (m_drain || (e_req && !imem.im_ready)) begin
                    m_drain = 1'b1;
                    m_redir = tgt;
                end else begin
                    m_pc    = tgt;
                    m_have  = 1'b0;
                    m_drain = 1'b0;
                end
            end else if (m_drain) begin
                if (imem.im_ready) begin
                    m_pc    = m_redir;
                    m_drain = 1'b0;
                end
            end else if (e_valid && en) begin
                m_pc   = br_take ? br_target : m_pc + 32'd4;
                m_have = 1'b0;
            end else if (e_valid && !m_have && !is_bad) begin
                m_have = 1'b1;
                m_word = imem.im_rdata;
            end
            tick();
        end
        rand_mode = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_hold();
        test_branch();
        test_interrupt_eret();
        test_bad_addr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
